// File: rtl/me_move_ctrl_pkg.sv
// Shared direction codes, default timing parameters and FSM state type for the move controller.
// Direction codes double as the low two bits of the internal owner encoding.
package me_move_ctrl_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int ME_DEBOUNCE_CNT  = 4;
  localparam int ME_HOLD_DELAY    = 8;
  localparam int ME_REPEAT_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_DELAY,
    ST_REPEAT
  } move_state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/me_move_ctrl_if.sv
// Button inputs and step outputs of the move controller.
// master = button/enable source, slave = the controller.
interface me_move_ctrl_if;

  logic       en_i;
  logic       key_up_i;
  logic       key_down_i;
  logic       key_left_i;
  logic       key_right_i;
  logic       move_en_o;
  logic [1:0] direct_o;

  modport master (
    output en_i, key_up_i, key_down_i, key_left_i, key_right_i,
    input  move_en_o, direct_o
  );

  modport slave (
    input  en_i, key_up_i, key_down_i, key_left_i, key_right_i,
    output move_en_o, direct_o
  );

endinterface

// File: rtl/me_move_ctrl_key_debounce.sv
// One button: 2-flop synchroniser plus debounce counter; level changes after 2+DEBOUNCE_CNT cycles.
// rise/fall are single-cycle strobes asserted in the cycle whose closing edge flips the level.
module me_move_ctrl_key_debounce
  import me_move_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = ME_DEBOUNCE_CNT
) (
  input  logic clk_run,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int DW = cnt_width(DEBOUNCE_CNT - 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;
  logic          flip;

  // The sample that completes the run of DEBOUNCE_CNT differing samples flips the level.
  assign flip = (sync2 != level) && (cnt == CNT_LAST);
  assign rise = flip & ~level;
  assign fall = flip & level;

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if ((sync2 == level) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
      if (flip) begin
        level <= ~level;
      end
    end
  end

endmodule

// File: rtl/me_move_ctrl.sv
// Four debounced buttons -> "last pressed wins" owner -> step pulses with typematic auto-repeat.
// First step 2+DEBOUNCE_CNT cycles after a press; no backpressure, en_i low suppresses steps.
module me_move_ctrl
  import me_move_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT  = ME_DEBOUNCE_CNT,
  parameter int HOLD_DELAY    = ME_HOLD_DELAY,
  parameter int REPEAT_PERIOD = ME_REPEAT_PERIOD
) (
  input  logic          clk_run,
  input  logic          rst,
  me_move_ctrl_if.slave bus
);

  localparam logic [2:0] OWN_NONE = 3'b100;

  localparam int CNT_MAX = ((HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD) - 1;
  localparam int CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] REP_LOAD  = CW'(REPEAT_PERIOD - 1);

  logic [3:0]    raw;
  logic [3:0]    level;
  logic [3:0]    rise;
  logic [3:0]    fall;

  logic [2:0]    owner;
  logic [2:0]    owner_nxt;
  move_state_t   state;
  move_state_t   state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          move_en;
  logic [1:0]    dir_last;

  // Bit index equals direction code, so bit 0 (UP) has the highest priority.
  assign raw = {bus.key_right_i, bus.key_left_i, bus.key_down_i, bus.key_up_i};

  for (genvar k = 0; k < 4; k++) begin : g_key
    me_move_ctrl_key_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
      .clk_run(clk_run),
      .rst    (rst),
      .key    (raw[k]),
      .level  (level[k]),
      .rise   (rise[k]),
      .fall   (fall[k])
    );
  end

  function automatic logic [2:0] pick(input logic [3:0] keys);
    logic [2:0] sel;
    sel = OWN_NONE;
    for (int k = 3; k >= 0; k--) begin
      if (keys[k]) sel = {1'b0, 2'(k)};
    end
    return sel;
  endfunction

  // A fresh press always wins; releasing the owner falls back to the best key still held.
  always_comb begin
    owner_nxt = owner;
    if (|rise) begin
      owner_nxt = pick(rise);
    end else if ((owner != OWN_NONE) && fall[owner[1:0]]) begin
      owner_nxt = pick(level & ~fall);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!bus.en_i || (owner_nxt == OWN_NONE)) begin
      state_nxt = ST_IDLE;
    end else if (owner_nxt != owner) begin
      state_nxt = ST_FIRST;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_FIRST;
        end
        ST_FIRST: begin
          cnt_nxt   = HOLD_LOAD;
          state_nxt = (HOLD_DELAY == 1) ? ST_REPEAT : ST_DELAY;
        end
        ST_DELAY: begin
          // Leave on the edge that brings the count to zero so REPEAT opens with a step.
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state_nxt = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          cnt_nxt = (cnt == '0) ? REP_LOAD : (cnt - CW'(1));
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      owner    <= OWN_NONE;
      state    <= ST_IDLE;
      cnt      <= '0;
      dir_last <= DIR_UP;
    end else begin
      owner <= owner_nxt;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (move_en) begin
        dir_last <= owner[1:0];
      end
    end
  end

  assign move_en      = bus.en_i && ((state == ST_FIRST) || ((state == ST_REPEAT) && (cnt == '0)));
  assign bus.move_en_o = move_en;
  assign bus.direct_o  = move_en ? owner[1:0] : dir_last;

endmodule
